// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets two requesters share one ALU.
// Each operation walks IDLE -> EXEC -> RESP, with operands and results held in registers.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_src1,
   input  logic [DATA_W-1:0] req0_src2,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_src1,
   input  logic [DATA_W-1:0] req1_src2,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   output logic [OP_W-1:0]   alu_operation,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nxt;
   logic last_grant, owner, grant, accept, rsp_done, zero_q;
   logic [OP_W-1:0] op_q;
   logic [DATA_W-1:0] src1_q, src2_q, result_q;
   always_comb begin
      grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      req0_ready = (state == IDLE) && !rst && req0_valid && !grant;
      req1_ready = (state == IDLE) && !rst && req1_valid && grant;
      accept = req0_ready || req1_ready;
      rsp0_valid = (state == RESP) && !owner;
      rsp1_valid = (state == RESP) && owner;
      rsp_done = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
      state_nxt = (state == IDLE && accept) ? EXEC :
                  (state == EXEC) ? RESP :
                  (state == RESP && !rsp_done) ? RESP : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nxt;
   end
   // last_grant resets to 1 so that requester 0 wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         op_q       <= '0;
         src1_q     <= '0;
         src2_q     <= '0;
         result_q   <= '0;
         zero_q     <= 1'b0;
      end else begin
         if (accept) begin
            owner  <= grant;
            op_q   <= grant ? req1_op : req0_op;
            src1_q <= grant ? req1_src1 : req0_src1;
            src2_q <= grant ? req1_src2 : req0_src2;
         end
         if (state == EXEC) begin
            result_q <= alu_result;
            zero_q   <= alu_zero;
         end
         if (rsp_done) last_grant <= owner;
      end
   end
   assign alu_src1      = src1_q;
   assign alu_src2      = src2_q;
   assign alu_operation = op_q;
   assign rsp0_result   = result_q;
   assign rsp1_result   = result_q;
   assign rsp0_zero     = zero_q;
   assign rsp1_zero     = zero_q;
   assign busy          = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table vectors plus hand-written sequences for alu_arbiter, with a
// behavioural shared ALU and a scoreboard of expected responses.
module tb_alu_arbiter;
   localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, BEQ = 5'd2, BNE = 5'd3,
                          BLT = 5'd4, BGE = 5'd5, BLTU = 5'd6, BGEU = 5'd7, UNK = 5'h1f;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
   logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, alu_zero, busy;
   logic [4:0] req0_op = '0, req1_op = '0, alu_operation;
   logic [31:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
   logic [31:0] rsp0_result, rsp1_result, alu_src1, alu_src2, alu_result;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(32), .OP_W(5)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_src1(req0_src1), .req0_src2(req0_src2),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_src1(req1_src1), .req1_src2(req1_src2),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_operation(alu_operation),
      .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy));

   // Unknown codes give a recognisable result so that forwarding of the raw code is visible
   function automatic logic [32:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         ADD:  r = a + b;
         SUB:  r = a - b;
         BEQ:  return {a == b, 32'h0};
         BNE:  return {a != b, 32'h0};
         BLT:  return {$signed(a) < $signed(b), 32'h0};
         BGE:  return {$signed(a) >= $signed(b), 32'h0};
         BLTU: return {a < b, 32'h0};
         BGEU: return {a >= b, 32'h0};
         default: return {op[0], 32'hdead0000 | {27'd0, op}};
      endcase
      return {r == 32'h0, r};
   endfunction
   assign {alu_zero, alu_result} = alu_f(alu_operation, alu_src1, alu_src2);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {logic id; logic [32:0] zr; logic br;} exp_t;
   exp_t sb[$];
   exp_t sb_e;
   int order[$];
   always @(negedge clk) begin
      if (rst) sb.delete();
      else begin
         if (req0_valid && req0_ready) begin
            sb.push_back('{1'b0, alu_f(req0_op, req0_src1, req0_src2), req0_op >= BEQ && req0_op <= BGEU});
            order.push_back(0);
         end
         if (req1_valid && req1_ready) begin
            sb.push_back('{1'b1, alu_f(req1_op, req1_src1, req1_src2), req1_op >= BEQ && req1_op <= BGEU});
            order.push_back(1);
         end
         if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               sb_e = sb.pop_front();
               chk("sb_owner", {63'd0, rsp1_valid}, {63'd0, sb_e.id});
               chk("sb_zero", sb_e.id ? rsp1_zero : rsp0_zero, sb_e.zr[32]);
               if (!sb_e.br) chk("sb_result", sb_e.id ? rsp1_result : rsp0_result, sb_e.zr[31:0]);
            end
         end
      end
   end

   task automatic issue(input logic id, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic got;
      @(posedge clk); #1;
      if (id) begin req1_valid = 1; req1_op = op; req1_src1 = a; req1_src2 = b; end
      else begin req0_valid = 1; req0_op = op; req0_src1 = a; req0_src2 = b; end
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = id ? req1_ready : req0_ready;
      end
      chk("accept_timeout", got, 1);
      @(posedge clk); #1;
      req0_valid = 0;
      req1_valid = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
      chk("drain_timeout", sb.size(), 0);
   endtask

   typedef struct {logic id; logic [4:0] op; logic [31:0] a, b, res; logic z, cres;} vec_t;
   vec_t vecs[9];
   logic got;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, ADD,  32'd5,        32'd7, 32'd12,       1'b0, 1'b1};
      vecs[1] = '{1'b1, SUB,  32'd10,       32'd3, 32'd7,        1'b0, 1'b1};
      vecs[2] = '{1'b0, BEQ,  32'd9,        32'd9, 32'd0,        1'b1, 1'b0};
      vecs[3] = '{1'b1, BNE,  32'd9,        32'd9, 32'd0,        1'b0, 1'b0};
      vecs[4] = '{1'b0, BLT,  32'hffffffff, 32'd1, 32'd0,        1'b1, 1'b0};
      vecs[5] = '{1'b1, BLTU, 32'hffffffff, 32'd1, 32'd0,        1'b0, 1'b0};
      vecs[6] = '{1'b0, ADD,  32'hffffffff, 32'd1, 32'd0,        1'b1, 1'b1};
      vecs[7] = '{1'b1, UNK,  32'd0,        32'd0, 32'hdead001f, 1'b1, 1'b1};
      vecs[8] = '{1'b0, BGE,  32'd3,        32'd3, 32'd0,        1'b1, 1'b0};
      // reset state, with both requesters pushing while rst is high
      req0_valid = 1;
      req1_valid = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
      chk("rst_alu", {alu_src1, alu_src2, alu_operation}, 0);
      chk("rst_rsp", {rsp0_result, rsp0_zero, rsp1_result, rsp1_zero}, 0);
      @(posedge clk); #1;
      rst = 0;
      req0_valid = 0;
      req1_valid = 0;
      // single ADD with cycle-by-cycle latency
      rsp0_ready = 1;
      @(posedge clk); #1;
      req0_valid = 1; req0_op = ADD; req0_src1 = 5; req0_src2 = 7;
      @(negedge clk);
      chk("lat_req0_ready", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 0;
      @(negedge clk);
      chk("lat_exec_busy", busy, 1);
      chk("lat_exec_rsp0", rsp0_valid, 0);
      chk("lat_exec_alu", {alu_operation, alu_src1, alu_src2}, {ADD, 32'd5, 32'd7});
      @(negedge clk);
      chk("lat_rsp0_valid", rsp0_valid, 1);
      chk("lat_rsp0_result", rsp0_result, 12);
      chk("lat_rsp1_valid", rsp1_valid, 0);
      chk("lat_ready_in_resp", {req0_ready, req1_ready}, 0);
      @(negedge clk);
      chk("lat_idle_busy", busy, 0);
      chk("lat_idle_rsp0", rsp0_valid, 0);
      // table vectors
      rsp1_ready = 1;
      foreach (vecs[i]) begin
         issue(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
         @(negedge clk);
         chk($sformatf("vec%0d_alu_op", i), alu_operation, vecs[i].op);
         chk($sformatf("vec%0d_alu_src", i), {alu_src1, alu_src2}, {vecs[i].a, vecs[i].b});
         got = 0;
         for (int k = 0; k < 5 && !got; k++) begin
            @(negedge clk);
            got = vecs[i].id ? rsp1_valid : rsp0_valid;
         end
         chk($sformatf("vec%0d_rsp_valid", i), got, 1);
         chk($sformatf("vec%0d_other_valid", i), vecs[i].id ? rsp0_valid : rsp1_valid, 0);
         if (vecs[i].cres) chk($sformatf("vec%0d_result", i), vecs[i].id ? rsp1_result : rsp0_result, vecs[i].res);
         chk($sformatf("vec%0d_zero", i), vecs[i].id ? rsp1_zero : rsp0_zero, vecs[i].z);
         drain();
      end
      // round-robin: both persist from reset, grants must go 0,1,0
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      order.delete();
      req0_valid = 1; req0_op = ADD; req0_src1 = 1; req0_src2 = 2;
      req1_valid = 1; req1_op = SUB; req1_src1 = 9; req1_src2 = 4;
      for (int i = 0; i < 40 && order.size() < 3; i++) @(negedge clk);
      @(posedge clk); #1;
      req0_valid = 0;
      req1_valid = 0;
      chk("tie_count", order.size(), 3);
      if (order.size() == 3) begin
         chk("tie_first", order[0], 0);
         chk("tie_second", order[1], 1);
         chk("tie_third", order[2], 0);
      end
      drain();
      // held response: requester 0 knocks meanwhile, then withdraws
      rsp1_ready = 0;
      issue(1, SUB, 3, 5);
      @(posedge clk); #1;
      req0_valid = 1; req0_op = ADD; req0_src1 = 1; req0_src2 = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("hold%0d", i), {rsp1_valid, rsp1_result, busy, req0_ready}, {1'b1, 32'hfffffffe, 1'b1, 1'b0});
      end
      @(posedge clk); #1;
      req0_valid = 0;
      rsp1_ready = 1;
      drain();
      @(posedge clk); #1;
      got = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         got = got | busy | rsp0_valid | rsp1_valid;
      end
      chk("withdrawn_no_accept", got, 0);
      // reset during EXEC discards the operation
      issue(0, ADD, 4, 4);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rexec_busy", busy, 0);
      chk("rexec_alu", {alu_src1, alu_src2, alu_operation}, 0);
      got = rsp0_valid;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         got = got | rsp0_valid;
      end
      chk("rexec_no_rsp", got, 0);
      chk("rexec_sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
